a_row_seed_gen: RTL and testbench

//  Consumer of the seedA storage serial output. Latches the 128-bit seedA (2x64-bit words)
//  and, per row i of matrix A, emits the SHAKE128 input block <i>16 || seedA as three
//  64-bit words to the A-row expander. Seed reuse across commands lets the storage be read

---
 rtl/a_row_seed_gen.sv | 243 ++++++++++++++++++++++++
 tb/tb_a_row_seed_gen.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a_row_seed_gen.sv
// a_row_seed_gen
//
// Takes the 128-bit seedA from the seed storage serial output as two 64-bit words and keeps it.
// For each row i of matrix A it then sends the SHAKE128 input block <i>16 || seedA to the A-row
// expander as three 64-bit words. The 18-byte message is little-endian, with byte 0 in
// bits [7:0] of word 0. Padding is added downstream.
//
// The seed stays valid across commands. A command with reload=0 therefore reuses it without
// reading the storage again.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   cmd             {reload, nRows[ROW_W-1:0]}; accepted when cmd_isReady & cmd_canReceive
//   in              seed word (word0 = seed[63:0], word1 = seed[127:64])
//   in_isLast       sender's last-word flag, cross-checked against the local word counter
//   out             row-block word; out_isLast marks word 2 of a row block,
//                   out_isLastRow marks the final word of the command
//   err_seed        sticky in_isLast mismatch flag, cleared by the next accepted command
//
// All valid/ready outputs come from registered state only. No input reaches them through a
// combinational path, apart from the reset gating of cmd_canReceive.

module a_row_seed_gen #(
  parameter int unsigned ROW_W = 11
) (
  input  logic             clk,
  input  logic             rst,

  input  logic [ROW_W:0]   cmd,
  input  logic             cmd_isReady,
  output logic             cmd_canReceive,

  input  logic [63:0]      in,
  input  logic             in_isReady,
  output logic             in_canReceive,
  input  logic             in_isLast,

  output logic [63:0]      out,
  output logic             out_isReady,
  input  logic             out_canReceive,
  output logic             out_isLast,
  output logic             out_isLastRow,

  output logic             err_seed
);

  typedef enum logic [1:0] {StIdle, StLoad, StEmit} state_e;

  state_e           state_q, state_d;
  logic [127:0]     seed_q, seed_d;
  logic             seed_valid_q, seed_valid_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic [ROW_W-1:0] n_rows_q, n_rows_d;
  logic [1:0]       word_cnt_q, word_cnt_d;
  logic             err_seed_q, err_seed_d;

  // Decoded command fields
  logic             cmd_reload;
  logic [ROW_W-1:0] cmd_n_rows;

  assign cmd_reload = cmd[ROW_W];
  assign cmd_n_rows = cmd[ROW_W-1:0];

  // Channel transfers
  logic cmd_fire;
  logic in_fire;
  logic out_fire;

  assign cmd_fire = cmd_isReady & cmd_canReceive;
  assign in_fire  = in_isReady  & in_canReceive;
  assign out_fire = out_isReady & out_canReceive;

  // Word position decodes, shared by next-state, datapath and output logic
  logic seed_hi_word;   // the incoming seed word is the second (upper) one
  logic last_word;      // word 2 of the current row block is being presented
  logic last_row;       // the current row is the final row of the command
  logic block_done;     // the final word of the final row is taken this cycle

  assign seed_hi_word = (word_cnt_q == 2'd1);
  assign last_word    = (word_cnt_q == 2'd2);
  // Only evaluated in StEmit, where n_rows_q >= 1, so the subtraction never wraps
  assign last_row     = (row_cnt_q == (n_rows_q - ROW_W'(1)));
  assign block_done   = out_fire & last_word & last_row;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          if (cmd_reload || !seed_valid_q) begin
            state_d = StLoad;
          end else if (cmd_n_rows == '0) begin
            state_d = StIdle;
          end else begin
            state_d = StEmit;
          end
        end
      end
      StLoad: begin
        if (in_fire && seed_hi_word) begin
          // A zero-row command only refreshes the seed
          state_d = (n_rows_q == '0) ? StIdle : StEmit;
        end
      end
      StEmit: begin
        if (block_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seed_q       <= '0;
      seed_valid_q <= 1'b0;
      row_cnt_q    <= '0;
      n_rows_q     <= '0;
      word_cnt_q   <= '0;
      err_seed_q   <= 1'b0;
    end else begin
      seed_q       <= seed_d;
      seed_valid_q <= seed_valid_d;
      row_cnt_q    <= row_cnt_d;
      n_rows_q     <= n_rows_d;
      word_cnt_q   <= word_cnt_d;
      err_seed_q   <= err_seed_d;
    end
  end

  always_comb begin
    seed_d       = seed_q;
    seed_valid_d = seed_valid_q;
    row_cnt_d    = row_cnt_q;
    n_rows_d     = n_rows_q;
    word_cnt_d   = word_cnt_q;
    err_seed_d   = err_seed_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          n_rows_d   = cmd_n_rows;
          row_cnt_d  = '0;
          word_cnt_d = '0;
          err_seed_d = 1'b0;
        end
      end
      StLoad: begin
        if (in_fire) begin
          if (seed_hi_word) begin
            seed_d[127:64] = in;
            seed_valid_d   = 1'b1;
            word_cnt_d     = 2'd0;
          end else begin
            seed_d[63:0] = in;
            word_cnt_d   = 2'd1;
          end
          // The sender's framing is only checked; the word is kept in either case
          if (in_isLast != seed_hi_word) begin
            err_seed_d = 1'b1;
          end
        end
      end
      StEmit: begin
        if (out_fire) begin
          if (last_word) begin
            word_cnt_d = 2'd0;
            row_cnt_d  = row_cnt_q + ROW_W'(1);
          end else begin
            word_cnt_d = word_cnt_q + 2'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  logic [15:0] row_idx16;
  logic [63:0] word_mux;

  assign row_idx16 = 16'(row_cnt_q);

  // Message bytes 0..1 hold the row index and bytes 2..17 hold the seed
  always_comb begin
    word_mux = '0;
    unique case (word_cnt_q)
      2'd0:    word_mux = {seed_q[47:0], row_idx16};
      2'd1:    word_mux = seed_q[111:48];
      2'd2:    word_mux = {48'h0, seed_q[127:112]};
      default: word_mux = '0;
    endcase
  end

  always_comb begin
    // rst gates cmd_canReceive so that every output is low while reset is held
    cmd_canReceive = rst && (state_q == StIdle);
    in_canReceive  = (state_q == StLoad);
    out_isReady    = (state_q == StEmit);
    out            = out_isReady ? word_mux : 64'h0;
    out_isLast     = out_isReady && last_word;
    out_isLastRow  = out_isReady && last_word && last_row;
    err_seed       = err_seed_q;
  end

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  // A stalled word is held unchanged until it is taken
  property p_out_hold;
    @(posedge clk) disable iff (!rst)
      (out_isReady && !out_canReceive) |=> (out_isReady && $stable(out));
  endproperty
  a_out_hold: assert property (p_out_hold);

  // At most one channel can be open at a time
  property p_one_channel;
    @(posedge clk) disable iff (!rst)
      !((in_canReceive && out_isReady) || (cmd_canReceive && (in_canReceive || out_isReady)));
  endproperty
  a_one_channel: assert property (p_one_channel);

endmodule

// File: tb/tb_a_row_seed_gen.sv
// Self-checking bench for a_row_seed_gen. Expected words come from a byte-level model of the
// 18-byte message <row>16 || seedA, split into little-endian 64-bit words.

module tb_a_row_seed_gen;

  logic        clk;
  logic        rst;
  logic [11:0] cmd;
  logic        cmd_isReady;
  logic        cmd_canReceive;
  logic [63:0] in;
  logic        in_isReady;
  logic        in_canReceive;
  logic        in_isLast;
  logic [63:0] out;
  logic        out_isReady;
  logic        out_canReceive;
  logic        out_isLast;
  logic        out_isLastRow;
  logic        err_seed;

  a_row_seed_gen #(.ROW_W(11)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd            (cmd),
    .cmd_isReady    (cmd_isReady),
    .cmd_canReceive (cmd_canReceive),
    .in             (in),
    .in_isReady     (in_isReady),
    .in_canReceive  (in_canReceive),
    .in_isLast      (in_isLast),
    .out            (out),
    .out_isReady    (out_isReady),
    .out_canReceive (out_canReceive),
    .out_isLast     (out_isLast),
    .out_isLastRow  (out_isLastRow),
    .err_seed       (err_seed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic timed_out;

  // Filled by drain(): {isLastRow, isLast, word} per accepted word
  logic [65:0] got_q[$];
  int          first_valid;
  int          drain_cycles;
  logic        in_seen;

  // Reference model: byte message -> 64-bit little-endian words
  function automatic logic [63:0] exp_word(input logic [127:0] seed, input int row, input int w);
    logic [7:0]  msg [24];
    logic [63:0] r;
    for (int b = 0; b < 24; b++) msg[b] = 8'h00;
    msg[0] = row[7:0];
    msg[1] = row[15:8];
    for (int b = 0; b < 16; b++) msg[2 + b] = seed[8*b +: 8];
    r = '0;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = msg[8*w + k];
    return r;
  endfunction

  function automatic logic [127:0] rand_seed();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // All stimulus tasks enter and leave at a falling edge
  task automatic send_cmd(input logic rl, input int n);
    int k = 0;
    cmd = {rl, 11'(n)};
    cmd_isReady = 1'b1;
    while (!cmd_canReceive && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) timed_out = 1'b1;
    @(negedge clk);
    cmd_isReady = 1'b0;
  endtask

  task automatic send_seed(input logic [127:0] s, input logic l0, input logic l1);
    for (int i = 0; i < 2; i++) begin
      int k = 0;
      in = (i == 0) ? s[63:0] : s[127:64];
      in_isLast = (i == 0) ? l0 : l1;
      in_isReady = 1'b1;
      while (!in_canReceive && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (k >= 200) timed_out = 1'b1;
      @(negedge clk);
    end
    in_isReady = 1'b0;
    in_isLast = 1'b0;
  endtask

  task automatic drain(input int nwords, input int budget);
    int cyc = 0;
    got_q.delete();
    first_valid = -1;
    in_seen = 1'b0;
    out_canReceive = 1'b1;
    while (got_q.size() < nwords && cyc < budget) begin
      if (in_canReceive) in_seen = 1'b1;
      if (out_isReady) begin
        if (first_valid < 0) first_valid = cyc;
        got_q.push_back({out_isLastRow, out_isLast, out});
      end
      @(negedge clk);
      cyc++;
    end
    out_canReceive = 1'b0;
    drain_cycles = cyc;
    if (got_q.size() < nwords) timed_out = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cmd_canReceive, in_canReceive, out_isReady, out_isLast, out_isLastRow, err_seed} !== 6'b0
        || out !== 64'h0) begin
      fails++;
      $display("FAIL reset_outputs got cr=%b ir=%b or=%b out=%h err=%b required all 0",
               cmd_canReceive, in_canReceive, out_isReady, out, err_seed);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cmd_canReceive !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_cmd_ready got %b required 1", cmd_canReceive);
    end
    @(negedge clk);
  endtask

  task automatic test_load_emit(input logic [127:0] s);
    logic [63:0] e;
    timed_out = 1'b0;
    send_cmd(1'b1, 3);
    send_seed(s, 1'b0, 1'b1);
    drain(9, 50);
    checks++;
    if (got_q.size() !== 9 || drain_cycles !== 9 || first_valid !== 0) begin
      fails++;
      $display("FAIL t1_count got n=%0d cyc=%0d first=%0d required 9/9/0",
               got_q.size(), drain_cycles, first_valid);
    end
    for (int i = 0; i < got_q.size() && i < 9; i++) begin
      e = exp_word(s, i / 3, i % 3);
      checks++;
      if (got_q[i] !== {(i == 8), (i % 3 == 2), e}) begin
        fails++;
        $display("FAIL t1_word%0d got %h required %h", i, got_q[i], {(i == 8), (i % 3 == 2), e});
      end
    end
    if (got_q.size() == 9) begin
      checks++;
      if (got_q[0][63:0] !== 64'h0504030201000000 || got_q[1][63:0] !== 64'h0D0C0B0A09080706
          || got_q[2][63:0] !== 64'h0000_0000_0000_0F0E || got_q[6][15:0] !== 16'h0002) begin
        fail_vec_print();
      end
    end
    checks++;
    if (cmd_canReceive !== 1'b1 || out_isReady !== 1'b0 || err_seed !== 1'b0 || timed_out) begin
      fails++;
      $display("FAIL t1_idle got cr=%b or=%b err=%b to=%b required 1 0 0 0",
               cmd_canReceive, out_isReady, err_seed, timed_out);
    end
  endtask

  task automatic fail_vec_print();
    fails++;
    $display("FAIL t1_vectors got %h %h %h row2=%h required 0504030201000000 0D0C0B0A09080706 0F0E 0002",
             got_q[0][63:0], got_q[1][63:0], got_q[2][63:0], got_q[6][15:0]);
  endtask

  task automatic test_reuse(input logic [127:0] s);
    timed_out = 1'b0;
    send_cmd(1'b0, 2);
    drain(6, 40);
    checks++;
    if (first_valid !== 0 || in_seen !== 1'b0 || got_q.size() !== 6 || drain_cycles !== 6) begin
      fails++;
      $display("FAIL t2_latency got first=%0d in_seen=%b n=%0d cyc=%0d required 0 0 6 6",
               first_valid, in_seen, got_q.size(), drain_cycles);
    end
    for (int i = 0; i < got_q.size() && i < 6; i++) begin
      checks++;
      if (got_q[i] !== {(i == 5), (i % 3 == 2), exp_word(s, i / 3, i % 3)}) begin
        fails++;
        $display("FAIL t2_word%0d got %h required %h", i, got_q[i],
                 {(i == 5), (i % 3 == 2), exp_word(s, i / 3, i % 3)});
      end
    end
    checks++;
    if (timed_out) begin
      fails++;
      $display("FAIL t2_timeout got 1 required 0");
    end
  endtask

  task automatic test_stalls();
    logic [127:0] s;
    logic [63:0]  e;
    logic [63:0]  last_w0;
    logic         acc;
    logic         oc;
    int           nprint = 0;
    timed_out = 1'b0;
    last_w0 = '0;
    s = rand_seed();
    send_cmd(1'b1, 1344);
    send_seed(s, 1'b0, 1'b1);
    for (int r = 0; r < 1344; r++) begin
      for (int w = 0; w < 3; w++) begin
        int k = 0;
        e = exp_word(s, r, w);
        acc = 1'b0;
        if (r == 1343 && w == 0) last_w0 = out;
        while (!acc && k < 64) begin
          checks++;
          if ({out_isReady, out_isLast, out_isLastRow, out} !==
              {1'b1, (w == 2), (w == 2 && r == 1343), e}) begin
            fails++;
            if (nprint < 10)
              $display("FAIL t3_word r=%0d w=%0d got %b%b%b %h required 1%b%b %h", r, w,
                       out_isReady, out_isLast, out_isLastRow, out,
                       (w == 2), (w == 2 && r == 1343), e);
            nprint++;
          end
          oc = ($urandom_range(0, 1) == 1);
          out_canReceive = oc;
          @(negedge clk);
          acc = oc;
          k++;
        end
        if (!acc) timed_out = 1'b1;
      end
    end
    out_canReceive = 1'b0;
    checks++;
    if (last_w0[15:0] !== 16'h053F) begin
      fails++;
      $display("FAIL t3_last_row_idx got %h required 053F", last_w0[15:0]);
    end
    checks++;
    if (cmd_canReceive !== 1'b1 || out_isReady !== 1'b0 || timed_out) begin
      fails++;
      $display("FAIL t3_idle got cr=%b or=%b to=%b required 1 0 0",
               cmd_canReceive, out_isReady, timed_out);
    end
  endtask

  task automatic test_zero_rows();
    logic [127:0] s;
    timed_out = 1'b0;
    s = rand_seed();
    send_cmd(1'b1, 0);
    send_seed(s, 1'b0, 1'b1);
    checks++;
    if (out_isReady !== 1'b0 || cmd_canReceive !== 1'b1 || in_canReceive !== 1'b0) begin
      fails++;
      $display("FAIL t4_zero_rows got or=%b cr=%b ir=%b required 0 1 0",
               out_isReady, cmd_canReceive, in_canReceive);
    end
    send_cmd(1'b0, 1);
    drain(3, 20);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== {(i == 2), (i == 2), exp_word(s, 0, i)}) begin
        fails++;
        $display("FAIL t4_word%0d got %h required %h", i,
                 (i < got_q.size()) ? got_q[i] : 66'h0, {(i == 2), (i == 2), exp_word(s, 0, i)});
      end
    end
    checks++;
    if (in_seen !== 1'b0 || timed_out) begin
      fails++;
      $display("FAIL t4_reuse got in_seen=%b to=%b required 0 0", in_seen, timed_out);
    end
  endtask

  task automatic test_seed_err();
    logic [127:0] s;
    timed_out = 1'b0;
    s = rand_seed();
    send_cmd(1'b1, 2);
    send_seed(s, 1'b1, 1'b1);
    checks++;
    if (err_seed !== 1'b1 || out_isReady !== 1'b1) begin
      fails++;
      $display("FAIL t5_err_set got err=%b or=%b required 1 1", err_seed, out_isReady);
    end
    drain(6, 40);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== {(i == 5), (i % 3 == 2), exp_word(s, i / 3, i % 3)}) begin
        fails++;
        $display("FAIL t5_word%0d got %h required %h", i,
                 (i < got_q.size()) ? got_q[i] : 66'h0,
                 {(i == 5), (i % 3 == 2), exp_word(s, i / 3, i % 3)});
      end
    end
    checks++;
    if (err_seed !== 1'b1) begin
      fails++;
      $display("FAIL t5_err_sticky got %b required 1", err_seed);
    end
    send_cmd(1'b0, 1);
    checks++;
    if (err_seed !== 1'b0) begin
      fails++;
      $display("FAIL t5_err_clear got %b required 0", err_seed);
    end
    drain(3, 20);
    checks++;
    if (got_q.size() !== 3 || got_q[0][63:0] !== exp_word(s, 0, 0) || timed_out) begin
      fails++;
      $display("FAIL t5_after_clear got n=%0d to=%b required 3 0", got_q.size(), timed_out);
    end
  endtask

  task automatic test_reset_abort();
    logic [127:0] s;
    logic [127:0] s2;
    timed_out = 1'b0;
    s = rand_seed();
    s2 = rand_seed();
    send_cmd(1'b1, 8);
    send_seed(s, 1'b0, 1'b1);
    drain(16, 40);
    checks++;
    if ({out_isReady, out} !== {1'b1, exp_word(s, 5, 1)}) begin
      fails++;
      $display("FAIL t6_pre_reset got %b %h required 1 %h", out_isReady, out, exp_word(s, 5, 1));
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({cmd_canReceive, in_canReceive, out_isReady, out_isLast, out_isLastRow, err_seed} !== 6'b0
        || out !== 64'h0) begin
      fails++;
      $display("FAIL t6_abort got or=%b out=%h cr=%b required all 0", out_isReady, out,
               cmd_canReceive);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_cmd(1'b0, 1);
    checks++;
    if (in_canReceive !== 1'b1 || out_isReady !== 1'b0) begin
      fails++;
      $display("FAIL t6_forced_load got ir=%b or=%b required 1 0", in_canReceive, out_isReady);
    end
    send_seed(s2, 1'b0, 1'b1);
    drain(3, 20);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== {(i == 2), (i == 2), exp_word(s2, 0, i)}) begin
        fails++;
        $display("FAIL t6_word%0d got %h required %h", i,
                 (i < got_q.size()) ? got_q[i] : 66'h0, {(i == 2), (i == 2), exp_word(s2, 0, i)});
      end
    end
    checks++;
    if (timed_out) begin
      fails++;
      $display("FAIL t6_timeout got 1 required 0");
    end
  endtask

  initial begin
    logic [127:0] s1;
    rst = 1'b0;
    cmd = '0;
    cmd_isReady = 1'b0;
    in = '0;
    in_isReady = 1'b0;
    in_isLast = 1'b0;
    out_canReceive = 1'b0;
    timed_out = 1'b0;
    s1 = 128'h0F0E0D0C0B0A0908_0706050403020100;
    @(negedge clk);
    test_reset();
    test_load_emit(s1);
    test_reuse(s1);
    test_stalls();
    test_zero_rows();
    test_seed_err();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
